// File: rtl/zest_ad7794_spi.sv
// zest_ad7794_spi: AD7794 SPI master (mode 3, DIV clk per SCLK half-period); optional RDY wait via ZEST_AD7794_RDY_WAIT_EN
module zest_ad7794_spi #(
  parameter int DIV = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rd,
  input  logic [2:0]  addr,
  input  logic [1:0]  nbytes,
  input  logic        reset_seq,
  input  logic        wait_rdy,
  input  logic [23:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [23:0] rdata,
  output logic        timeout,
  output logic        U18_CS,
  output logic        U18_SCLK,
  output logic        U18_DIN,
  output logic        U18_CLK,
  input  logic        U18_DOUT_RDY
);
  typedef enum logic [2:0] {IDLE, SETUP, WAIT_RDY, SHIFT, HOLD, GAP} state_t;
  localparam logic [8:0] DIV_M1 = 9'(DIV - 1);
  localparam logic [8:0] HALF = 9'(DIV);
  localparam logic [8:0] BIT_M1 = 9'(2 * DIV - 1);
  localparam logic [8:0] SMP = 9'(DIV - 2);
`ifdef ZEST_AD7794_RDY_WAIT_EN
  localparam logic WAIT_EN = 1'b1;
`else
  localparam logic WAIT_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [8:0] cnt, cnt_n;
  logic [4:0] bit_cnt, bit_cnt_n, last_bit;
  logic [31:0] tx, tx_n;
  logic rd_q, clr_q, wait_q, rdy_low, rdy_to;
  assign U18_CLK = 1'b0;
  // next state, phase counter and transmit shifter
  always_comb begin
    state_n = state;
    cnt_n = cnt + 9'd1;
    bit_cnt_n = bit_cnt;
    tx_n = tx;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = SETUP;
          tx_n = reset_seq ? '1 : {1'b0, rd, addr, 3'b000, wdata << (8 * (3 - nbytes))};
        end
      end
      SETUP: if (cnt == DIV_M1) begin
        cnt_n = '0;
        state_n = wait_q ? WAIT_RDY : SHIFT;
      end
      WAIT_RDY: begin
        cnt_n = '0;
        state_n = rdy_low ? SHIFT : rdy_to ? HOLD : WAIT_RDY;
      end
      SHIFT: if (cnt == BIT_M1) begin
        cnt_n = '0;
        tx_n = {tx[30:0], 1'b1};
        bit_cnt_n = bit_cnt == last_bit ? 5'd0 : bit_cnt + 5'd1;
        state_n = bit_cnt == last_bit ? HOLD : SHIFT;
      end
      HOLD: if (cnt == DIV_M1) begin
        cnt_n = '0;
        state_n = GAP;
      end
      GAP: if (cnt == DIV_M1) begin
        cnt_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, request latch and registered pin/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      tx <= '1;
      last_bit <= '0;
      rd_q <= 1'b0;
      clr_q <= 1'b0;
      wait_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      U18_CS <= 1'b1;
      U18_SCLK <= 1'b1;
      U18_DIN <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_cnt_n;
      tx <= tx_n;
      if (state == IDLE && start) begin
        last_bit <= reset_seq ? 5'd31 : {nbytes, 3'b111};
        rd_q <= rd & ~reset_seq;
        clr_q <= rd | reset_seq;
        wait_q <= wait_rdy & WAIT_EN & ~reset_seq;
      end
      busy <= state_n != IDLE;
      done <= state == GAP && cnt == DIV_M1;
      U18_CS <= !(state_n inside {SETUP, WAIT_RDY, SHIFT, HOLD});
      U18_SCLK <= !(state_n == SHIFT && cnt_n < HALF);
      U18_DIN <= state_n == SHIFT ? tx_n[31] : 1'b1;
    end
  end
  // read shifter: cleared as a read or reset frame starts clocking, then fills after the command byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (state != SHIFT && state_n == SHIFT && clr_q) rdata <= '0;
    else if (state == SHIFT && cnt == SMP && rd_q && |bit_cnt[4:3]) rdata <= {rdata[22:0], U18_DOUT_RDY};
  end
`ifdef ZEST_AD7794_RDY_WAIT_EN
  localparam logic [19:0] TO_M1 = 20'(TIMEOUT - 1);
  logic [1:0] rdy_sync;
  logic [19:0] to_cnt;
  assign rdy_low = !rdy_sync[1];
  assign rdy_to = to_cnt == TO_M1;
  // RDY synchronizer and wait budget, running only while waiting; sticky timeout until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_sync <= 2'b11;
      to_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      rdy_sync <= state == WAIT_RDY ? {rdy_sync[0], U18_DOUT_RDY} : 2'b11;
      to_cnt <= state == WAIT_RDY ? to_cnt + 20'd1 : '0;
      if (state == IDLE && start) timeout <= 1'b0;
      else if (state == WAIT_RDY && !rdy_low && rdy_to) timeout <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT == 0;
  assign rdy_low = 1'b1;
  assign rdy_to = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_zest_ad7794_spi.sv
// tb_zest_ad7794_spi: randomized scoreboard bench with an AD7794 slave model for zest_ad7794_spi
`timescale 1ns/1ps
module tb_zest_ad7794_spi;
  localparam int DIV = 4;
  localparam int TIMEOUT = 100;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rd = 1'b0, reset_seq = 1'b0, wait_rdy = 1'b0;
  logic [2:0] addr = '0;
  logic [1:0] nbytes = '0;
  logic [23:0] wdata = '0;
  logic busy, done, timeout_o, cs, sclk, din, uclk, dout;
  logic [23:0] rdata;
  int errors = 0, checks = 0, cyc = 0;

  zest_ad7794_spi #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rd(rd), .addr(addr), .nbytes(nbytes),
    .reset_seq(reset_seq), .wait_rdy(wait_rdy), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .timeout(timeout_o), .U18_CS(cs), .U18_SCLK(sclk), .U18_DIN(din),
    .U18_CLK(uclk), .U18_DOUT_RDY(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // AD7794 slave: response bits after the command byte, RDY level otherwise
  logic [23:0] slv_resp = '0;
  int slv_nb = 0, slv_j = 0;
  logic rdy_level = 1'b1, slv_bit = 1'b1;
  int fall_tot = 0, rise_tot = 0, fbase = 0, rbase = 0;
  bit din_log [8192];
  always @(negedge cs) begin fbase = fall_tot; rbase = rise_tot; end
  always @(negedge sclk) if (!cs) begin
    slv_j = fall_tot - fbase - 8;
    slv_bit = (slv_j >= 0 && slv_j < 8 * slv_nb) ? slv_resp[8 * slv_nb - 1 - slv_j] : 1'b1;
    fall_tot++;
  end
  always @(posedge sclk) if (!cs) begin din_log[rise_tot % 8192] = din; rise_tot++; end
  assign dout = (!cs && fall_tot != fbase) ? slv_bit : rdy_level;

  typedef struct { logic [23:0] rdata; logic to; int done_at; int falls; logic [31:0] din; } exp_t;
  exp_t sb[$];
  exp_t me;
  logic [31:0] mw;
  logic [23:0] model_rdata = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every done pops one expectation and compares the whole frame
  always @(negedge clk) if (done) begin
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: got done with no pending request at cycle %0d, expected none", cyc);
    end else begin
      me = sb.pop_front();
      mw = '0;
      for (int i = rbase; i < rise_tot; i++) mw = {mw[30:0], din_log[i % 8192]};
      check("rdata", rdata, me.rdata);
      check("timeout", timeout_o, me.to);
      check("sclk_falls", fall_tot - fbase, me.falls);
      check("din_bits", mw, me.din);
      check("busy_at_done", busy, 0);
      check("cs_at_done", cs, 1);
      if (me.done_at >= 0) check("done_cycle", cyc, me.done_at);
    end
  end

  // mode 0: normal timing, 1: wait of unknown length, 2: RDY timeout
  task automatic issue(input logic r, input logic [2:0] a, input logic [1:0] nb, input logic rs,
                       input logic w, input logic [23:0] wd, input logic [23:0] resp, input int mode);
    exp_t e;
    int nbits, g;
    longint cmd, mult;
    g = 0;
    while (busy && g < 2000) begin @(negedge clk); g++; end
    if (busy) check("idle_wait", busy, 0);
    rd = r; addr = a; nbytes = nb; reset_seq = rs; wait_rdy = w; wdata = wd; start = 1'b1;
    slv_resp = resp;
    slv_nb = (r && !rs) ? int'(nb) : 0;
    nbits = rs ? 32 : 8 * (int'(nb) + 1);
    mult = longint'(1) << (8 * int'(nb));
    cmd = (r ? 64 : 0) + longint'(a) * 8;
    e.din = rs ? 32'hFFFF_FFFF : 32'(cmd * mult + longint'(wd) % mult);
    if (mode != 2) model_rdata = rs ? 24'd0 : r ? 24'(longint'(resp) % mult) : model_rdata;
    e.rdata = model_rdata;
    e.to = mode == 2;
    e.falls = mode == 2 ? 0 : nbits;
    if (mode == 2) e.din = '0;
    e.done_at = mode == 0 ? cyc + 1 + DIV * (3 + 2 * nbits) : mode == 2 ? cyc + 1 + 3 * DIV + TIMEOUT : -1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    {rd, reset_seq, wait_rdy} = 3'($urandom);
    addr = 3'($urandom);
    nbytes = 2'($urandom);
    wdata = 24'($urandom);
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    do begin @(negedge clk); g++; end while (!done && g < 3000);
    if (!done) check("done_timeout", done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 1);
    check("rst_din", din, 1);
    check("rst_uclk", uclk, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1, 3'd0, 2'd1, 0, 0, 24'h0, 24'h000088, 0);
    wait_done();
    issue(0, 3'd1, 2'd2, 0, 0, 24'h00200A, 24'($urandom), 0);
    wait_done();
    issue(0, 3'($urandom), 2'($urandom), 1, 0, 24'($urandom), 24'($urandom), 0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (94) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);
    issue(1, 3'd2, 2'd2, 0, 0, 24'h0, 24'($urandom), 0);
    wait_done();
    issue(1, 3'd5, 2'd3, 0, 0, 24'h0, 24'($urandom), 0);
    repeat (60) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 1);
    check("abort_din", din, 1);
    check("abort_busy", busy, 0);
    sb.delete();
    model_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_rdata", rdata, 0);
    @(negedge clk);
    issue(1, 3'd0, 2'd1, 0, 0, 24'h0, 24'($urandom), 0);
    wait_done();
`ifdef ZEST_AD7794_RDY_WAIT_EN
    issue(1, 3'd3, 2'd2, 0, 1, 24'h0, 24'($urandom), 1);
    repeat (48) @(negedge clk);
    check("wait_cs_low", cs, 0);
    check("wait_sclk_idle", sclk, 1);
    @(negedge clk);
    rdy_level = 1'b0;
    wait_done();
    rdy_level = 1'b1;
    issue(1, 3'd2, 2'd3, 0, 1, 24'h0, 24'($urandom), 2);
    wait_done();
    issue(1, 3'd0, 2'd1, 0, 0, 24'h0, 24'($urandom), 0);
    wait_done();
`else
    issue(1, 3'd3, 2'd2, 0, 1, 24'h0, 24'($urandom), 0);
    wait_done();
    issue(0, 3'd2, 2'd3, 0, 1, 24'($urandom), 24'($urandom), 0);
    wait_done();
`endif
    for (int k = 0; k < 14; k++) begin
`ifdef ZEST_AD7794_RDY_WAIT_EN
      issue(1'($urandom), 3'($urandom), 2'($urandom), $urandom_range(0, 5) == 0, 0,
            24'($urandom), 24'($urandom), 0);
`else
      issue(1'($urandom), 3'($urandom), 2'($urandom), $urandom_range(0, 5) == 0, 1'($urandom),
            24'($urandom), 24'($urandom), 0);
`endif
      if (k % 3 == 0) wait_done();
    end
    wait_done();
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/zest_ad7794_spi.md
# zest_ad7794_spi

SPI master for the AD7794 thermometer ADC on the Zest board, driving the carrier-side `U18_*` signals of the Zest interface. Converts single-register host requests into AD7794 serial frames: command byte plus 0–3 data bytes, or the 32-ones serial reset. Sits between local-bus register logic and the Zest pin interface. All SPI timing derives from `clk` by a programmable divider.

## Interface
- `DIV`, 4: SCLK half-period in `clk` cycles; legal range 2–255.
- `TIMEOUT`, 65535: maximum `clk` cycles spent in WAIT_RDY; legal range 1–2^20−1; `ZEST_AD7794_RDY_WAIT_EN` only.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse; accepted only when `busy`=0.
- `rd` in 1: 1 = read, 0 = write.
- `addr` in 3: AD7794 register address.
- `nbytes` in 2: data bytes following the command byte, 0–3.
- `reset_seq` in 1: sampled with `start`; 1 = send 32 ones and ignore `rd`/`addr`/`nbytes`.
- `wait_rdy` in 1: sampled with `start`; wait for DOUT/RDY low before the command byte.
- `wdata` in 24: write data, low `nbytes*8` bits, MSB first.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 24: read data, right-justified, upper bits zero.
- `timeout` out 1: last transaction aborted on RDY timeout; valid with `done`.
- `U18_CS` out 1: chip select, active low.
- `U18_SCLK` out 1: serial clock, idle high.
- `U18_DIN` out 1: MOSI.
- `U18_CLK` out 1: tied 0, selects the AD7794 internal oscillator.
- `U18_DOUT_RDY` in 1: MISO and ready flag.

## Operation
- Command byte is {1'b0, `rd`, `addr`, 3'b000}. Frame length is 8·(1+`nbytes`) bits, or 32 bits when `reset_seq`=1.
- SPI mode 3:
  - SCLK falls and the next DIN bit is driven at the start of each bit.
  - SCLK rises DIV cycles later.
  - DOUT is registered on the `clk` cycle before the SCLK rise, giving DIV−1 cycles of slave access time.
- Bits sampled during the command byte are discarded. Read bits shift into `rdata`, MSB first.
- A write leaves `rdata` unchanged. A read with `nbytes`=0 clears `rdata`. A reset sequence clears `rdata`.
- States:
  - IDLE: on `start`, latch the request and go to SETUP; `busy` rises.
  - SETUP: CS low for DIV cycles, then SHIFT, or WAIT_RDY if `wait_rdy` is set and the feature is compiled in.
  - WAIT_RDY: wait for synchronized DOUT/RDY low, then go to SHIFT.
  - SHIFT: 2·DIV cycles per bit; after the last bit go to HOLD.
  - HOLD: SCLK high for DIV cycles, then CS rises and the FSM enters GAP.
  - GAP: CS high for DIV cycles, then pulse `done`, drop `busy` and return to IDLE.
- `start` while `busy`=1 is ignored and not queued. Request inputs are don't-care except in the accept cycle.
- Async reset mid-frame: CS and SCLK return high immediately and the frame is abandoned. The host must re-issue the AD7794 serial reset.

## Timing
- Reset values:
  - `U18_CS`=1, `U18_SCLK`=1, `U18_DIN`=1, `U18_CLK`=0.
  - `busy`=0, `done`=0, `timeout`=0, `rdata`=0.
- All outputs are registered.
- Accept-cycle numbering:
  - Cycle 0 is the `start` accept cycle.
  - `busy` and CS low appear at cycle 1.
  - The first SCLK fall is at cycle 1+DIV.
- Without a wait, `done` is at cycle 1+DIV·(3+2·N), where N is the frame bit count.
  - DIV=4 with 4-byte frame or reset: cycle 269.
  - DIV=4 with `nbytes`=0: cycle 77.
- `busy` falls in the `done` cycle. A `start` in the following cycle is accepted.
- DOUT/RDY uses a 2-flop synchronizer in WAIT_RDY only. SHIFT samples raw because timing is constrained by DIV.

## Configuration
- `ZEST_AD7794_RDY_WAIT_EN` defined:
  - WAIT_RDY state, synchronizer and TIMEOUT counter are built.
  - A read with `wait_rdy`=1 holds CS low until DOUT/RDY is low.
  - On TIMEOUT expiry: go to HOLD without clocking, leave `rdata` unchanged, and set `timeout`=1 with `done`.
  - `timeout` clears on the next accept.
- Undefined:
  - `wait_rdy` is ignored, `timeout` is constant 0, and the TIMEOUT parameter is unused.

## Test plan
- Read status (`rd`=1, `addr`=0, `nbytes`=1, DIV=4), slave model returns 0x88 → DIN byte 0x40, `rdata`=0x000088, `done` at cycle 141.
- Write mode register (`rd`=0, `addr`=1, `nbytes`=2, `wdata`=0x00200A) → DIN bytes 0x08, 0x20, 0x0A; 24 SCLK falls; `rdata` unchanged.
- `reset_seq`=1 → 32 SCLK cycles with DIN=1 throughout, CS low for the whole frame, `rdata`=0, `done` at cycle 269.
- `start` pulsed at cycles 5 and 100 of a transaction → exactly one frame, single `done`; new `start` in the cycle after `done` is accepted.
- `rst_n` low mid-SHIFT → CS, SCLK and DIN high and `busy`=0 in the same cycle; after release a normal read completes.
- RDY wait, macro defined, `wait_rdy`=1:
  - DOUT/RDY low after 50 cycles → SHIFT starts; read completes with `timeout`=0.
  - DOUT/RDY held high, TIMEOUT=100 → `done` with `timeout`=1, zero SCLK edges.
